fc_ctrl: RTL

FC_CTRL -- requirements
Module: fc_ctrl

---
 rtl/fc_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fc_ctrl.sv
// fc_ctrl -- sequencer for a fully-connected layer (M rows x N inputs).
//
// Loads an N-word input vector into an external memory, then for each of the
// M output rows streams N (x, w) read addresses to the memories, drives the
// MAC enable/clear strobes one cycle later (memory read latency), waits for
// the MAC pipeline to drain, and presents the row result downstream.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   input_valid   upstream word available          (LOAD only)
//   input_ready   block accepts a word              (high only in LOAD)
//   output_valid  accumulator holds a finished row  (high only in OUTPUT)
//   output_ready  downstream takes the row result   (OUTPUT only)
//   x_wr_en       input-memory write strobe
//   x_addr        input-memory address (write in LOAD, read in COMPUTE)
//   w_addr        weight-ROM read address, m*N + k
//   mac_en        accumulate current product
//   mac_clr       load product instead of adding (first term of a row)
module fc_ctrl #(
  parameter int M       = 4,
  parameter int N       = 4,
  parameter int MAC_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     input_valid,
  output logic                     input_ready,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic                     x_wr_en,
  output logic [$clog2(N)-1:0]     x_addr,
  output logic [$clog2(M*N)-1:0]   w_addr,
  output logic                     mac_en,
  output logic                     mac_clr
);

  localparam int NW = $clog2(N);
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int WW = $clog2(M*N);

  localparam logic [NW-1:0] N_LAST  = NW'(N - 1);
  localparam logic [MW-1:0] M_LAST  = MW'(M - 1);
  localparam logic [WW-1:0] N_W     = WW'(N);
  // WAIT counts 0..MAC_LAT, i.e. 1+MAC_LAT cycles: one for the memory
  // read of the last term, MAC_LAT for the MAC pipeline.
  localparam logic [2:0]    WC_LAST = 3'(MAC_LAT);

  typedef enum logic [1:0] {LOAD, COMPUTE, WAIT, OUTPUT} state_t;

  state_t          state, state_nxt;
  logic [NW-1:0]   n, n_nxt;      // load count
  logic [NW-1:0]   k, k_nxt;      // term index within a row
  logic [MW-1:0]   m, m_nxt;      // row index
  logic [2:0]      wc, wc_nxt;    // drain counter
  logic            issue;         // a (x, w) read is issued this cycle
  logic            issue_first;   // ...and it is term 0 of the row

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= LOAD;
      n       <= '0;
      k       <= '0;
      m       <= '0;
      wc      <= '0;
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
    end else begin
      state   <= state_nxt;
      n       <= n_nxt;
      k       <= k_nxt;
      m       <= m_nxt;
      wc      <= wc_nxt;
      // Memory data arrives one cycle after the address, so the MAC strobes
      // are the issue flags delayed by one register.
      mac_en  <= issue;
      mac_clr <= issue_first;
    end
  end

  always_comb begin
    state_nxt    = state;
    n_nxt        = n;
    k_nxt        = k;
    m_nxt        = m;
    wc_nxt       = wc;
    issue        = 1'b0;
    issue_first  = 1'b0;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    x_wr_en      = 1'b0;
    x_addr       = k;
    w_addr       = '0;

    case (state)
      LOAD: begin
        input_ready = 1'b1;
        // Gated by reset so no write strobe escapes while reset is held.
        x_wr_en     = input_valid && reset;
        x_addr      = n;
        if (input_valid) begin
          if (n == N_LAST) begin
            n_nxt     = '0;
            k_nxt     = '0;
            m_nxt     = '0;
            state_nxt = COMPUTE;
          end else begin
            n_nxt = n + 1'b1;
          end
        end
      end

      COMPUTE: begin
        issue       = 1'b1;
        issue_first = (k == '0);
        x_addr      = k;
        w_addr      = WW'(m) * N_W + WW'(k);
        if (k == N_LAST) begin
          k_nxt     = '0;
          wc_nxt    = '0;
          state_nxt = WAIT;
        end else begin
          k_nxt = k + 1'b1;
        end
      end

      WAIT: begin
        if (wc == WC_LAST) begin
          wc_nxt    = '0;
          state_nxt = OUTPUT;
        end else begin
          wc_nxt = wc + 1'b1;
        end
      end

      OUTPUT: begin
        output_valid = 1'b1;
        if (output_ready) begin
          if (m == M_LAST) begin
            m_nxt     = '0;
            n_nxt     = '0;
            state_nxt = LOAD;
          end else begin
            m_nxt     = m + 1'b1;
            state_nxt = COMPUTE;
          end
        end
      end

      default: state_nxt = LOAD;
    endcase
  end

endmodule
